// File: rtl/rom_byte_streamer.sv
// Purpose: turn 32-bit big-endian ROM file words into the paced byte-wide ioctl download stream.
// Latency: first ioctl_wr one cycle after a word is accepted; bytes WRITE_GAP cycles apart within a word.
// Backpressure: word_ready is high only while fetching, so at most one word is held; an idle source just stalls the stream.
//
// Ports:
//   clk, reset_n                  PPU-domain clock, asynchronous active-low reset
//   start, file_size              begin a transfer of file_size bytes (honoured only when idle)
//   word_valid, word_data         file words from the host bridge, first byte in [31:24]
//   word_ready                    a word is accepted this cycle when word_valid is also high
//   ioctl_download/wr/dout/addr   byte-serial download stream towards the core
//   busy, done                    transfer in progress / one-cycle completion pulse
module rom_byte_streamer #(
    parameter int WRITE_GAP   = 8,
    parameter int TAIL_CYCLES = 16
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        start,
    input  logic [31:0] file_size,
    input  logic        word_valid,
    input  logic [31:0] word_data,
    output logic        word_ready,
    output logic        ioctl_download,
    output logic        ioctl_wr,
    output logic [7:0]  ioctl_dout,
    output logic [24:0] ioctl_addr,
    output logic        busy,
    output logic        done
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_FETCH = 3'd1,
        S_EMIT  = 3'd2,
        S_GAP   = 3'd3,
        S_TAIL  = 3'd4
    } state_t;

    localparam logic [31:0] GAP_RELOAD  = 32'(WRITE_GAP - 2);
    localparam logic [31:0] TAIL_RELOAD = 32'(TAIL_CYCLES - 1);

    state_t      state;
    state_t      state_nxt;
    logic [31:0] remaining;
    logic [24:0] addr;
    logic [2:0]  byte_idx;
    logic [31:0] word_q;
    logic [31:0] cnt;
    logic        cnt_zero;
    logic        done_q;
    logic [7:0]  byte_sel;

    assign cnt_zero = (cnt == 32'd0);

    // State register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state and strobe outputs.
    always_comb begin
        state_nxt  = state;
        word_ready = 1'b0;
        ioctl_wr   = 1'b0;
        case (state)
            S_IDLE: begin
                if (start) begin
                    state_nxt = (file_size != 32'd0) ? S_FETCH : S_TAIL;
                end
            end
            S_FETCH: begin
                word_ready = 1'b1;
                if (word_valid) begin
                    state_nxt = S_EMIT;
                end
            end
            S_EMIT: begin
                ioctl_wr  = 1'b1;
                state_nxt = S_GAP;
            end
            S_GAP: begin
                // remaining has already been decremented for the byte just
                // emitted, so a zero here means the file is complete and no
                // further EMIT can underflow it.
                if (cnt_zero) begin
                    if (remaining == 32'd0) begin
                        state_nxt = S_TAIL;
                    end else if (byte_idx == 3'd4) begin
                        state_nxt = S_FETCH;
                    end else begin
                        state_nxt = S_EMIT;
                    end
                end
            end
            S_TAIL: begin
                if (cnt_zero) begin
                    state_nxt = S_IDLE;
                end
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase
    end

    // Datapath: byte counter, address, word holding register and the shared
    // gap/tail down-counter.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            remaining <= 32'd0;
            addr      <= 25'd0;
            byte_idx  <= 3'd0;
            word_q    <= 32'd0;
            cnt       <= 32'd0;
            done_q    <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (start) begin
                        remaining <= file_size;
                        addr      <= 25'd0;
                        byte_idx  <= 3'd0;
                        // Only consumed when a zero-length file goes straight to TAIL.
                        cnt       <= TAIL_RELOAD;
                    end
                end
                S_FETCH: begin
                    if (word_valid) begin
                        word_q   <= word_data;
                        byte_idx <= 3'd0;
                    end
                end
                S_EMIT: begin
                    addr      <= addr + 25'd1;
                    remaining <= remaining - 32'd1;
                    byte_idx  <= byte_idx + 3'd1;
                    // GAP lasts WRITE_GAP-1 cycles, counting down to zero.
                    cnt       <= GAP_RELOAD;
                end
                S_GAP: begin
                    if (!cnt_zero) begin
                        cnt <= cnt - 32'd1;
                    end else if (remaining == 32'd0) begin
                        cnt <= TAIL_RELOAD;
                    end
                end
                S_TAIL: begin
                    if (!cnt_zero) begin
                        cnt <= cnt - 32'd1;
                    end else begin
                        // Registered so it coincides with ioctl_download falling.
                        done_q <= 1'b1;
                    end
                end
                default: begin
                    cnt <= 32'd0;
                end
            endcase
        end
    end

    // MSB-first byte selection from the held word.
    always_comb begin
        byte_sel = 8'h00;
        case (byte_idx[1:0])
            2'd0:    byte_sel = word_q[31:24];
            2'd1:    byte_sel = word_q[23:16];
            2'd2:    byte_sel = word_q[15:8];
            default: byte_sel = word_q[7:0];
        endcase
    end

    // Outputs decode from the state register, so reset clears them at once.
    assign ioctl_download = (state != S_IDLE);
    assign busy           = (state != S_IDLE);
    assign done           = done_q;
    assign ioctl_dout     = (state == S_EMIT) ? byte_sel : 8'h00;
    assign ioctl_addr     = (state == S_IDLE) ? 25'd0 : addr;

endmodule

// File: tb/tb_rom_byte_streamer.sv
module tb_rom_byte_streamer;

    localparam int WG = 8;
    localparam int TC = 16;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        start = 1'b0;
    logic [31:0] file_size = 32'd0;
    logic        word_valid = 1'b0;
    logic [31:0] word_data = 32'd0;
    logic        word_ready;
    logic        ioctl_download;
    logic        ioctl_wr;
    logic [7:0]  ioctl_dout;
    logic [24:0] ioctl_addr;
    logic        busy;
    logic        done;

    int n_cmp = 0;
    int n_fail = 0;

    rom_byte_streamer #(.WRITE_GAP(WG), .TAIL_CYCLES(TC)) dut (
        .clk(clk),
        .reset_n(reset_n),
        .start(start),
        .file_size(file_size),
        .word_valid(word_valid),
        .word_data(word_data),
        .word_ready(word_ready),
        .ioctl_download(ioctl_download),
        .ioctl_wr(ioctl_wr),
        .ioctl_dout(ioctl_dout),
        .ioctl_addr(ioctl_addr),
        .busy(busy),
        .done(done)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Observation log, sampled mid-cycle.
    logic [7:0]  wr_dat[$];
    logic [24:0] wr_addr[$];
    int          wr_cyc[$];
    int          done_cnt = 0;
    int          done_cyc = 0;
    int          dl_cnt = 0;

    always @(negedge clk) begin
        if (ioctl_wr === 1'b1) begin
            wr_dat.push_back(ioctl_dout);
            wr_addr.push_back(ioctl_addr);
            wr_cyc.push_back(cyc);
        end
        if (done === 1'b1) begin
            done_cnt = done_cnt + 1;
            done_cyc = cyc;
        end
        if (ioctl_download === 1'b1) dl_cnt = dl_cnt + 1;
    end

    // Word source: presents the head of feed_q unless stalled.
    logic [31:0] feed_q[$];
    bit          stall = 1'b0;
    int          accepts = 0;
    int          accept_cyc = 0;

    always @(negedge clk) begin
        if (feed_q.size() > 0 && !stall) begin
            word_valid = 1'b1;
            word_data  = feed_q[0];
            if (word_ready === 1'b1) begin
                void'(feed_q.pop_front());
                accepts    = accepts + 1;
                accept_cyc = cyc;
            end
        end else begin
            word_valid = 1'b0;
        end
    end

    task automatic clear_log();
        wr_dat.delete();
        wr_addr.delete();
        wr_cyc.delete();
        dl_cnt  = 0;
        accepts = 0;
    endtask

    task automatic pulse_start(input logic [31:0] fs, output int s);
        @(negedge clk);
        start     = 1'b1;
        file_size = fs;
        s         = cyc;
        @(negedge clk);
        start     = 1'b0;
    endtask

    task automatic wait_done(input int budget, output bit ok);
        int d0;
        d0 = done_cnt;
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            #1;
            if (done_cnt != d0) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic test_reset();
        #12;
        n_cmp++; if (ioctl_download !== 1'b0 || busy !== 1'b0 || word_ready !== 1'b0) begin
            n_fail++; $display("FAIL reset_ctrl: dl=%b busy=%b rdy=%b want 0 0 0", ioctl_download, busy, word_ready); end
        n_cmp++; if (ioctl_wr !== 1'b0 || done !== 1'b0) begin
            n_fail++; $display("FAIL reset_strobes: wr=%b done=%b want 0 0", ioctl_wr, done); end
        n_cmp++; if (ioctl_dout !== 8'h00 || ioctl_addr !== 25'd0) begin
            n_fail++; $display("FAIL reset_data: dout=%h addr=%h want 00 0", ioctl_dout, ioctl_addr); end
        @(negedge clk);
        reset_n = 1'b1;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_eight_byte();
        logic [7:0] exp_b [8];
        int s;
        bit ok;
        exp_b = '{8'h4E, 8'h45, 8'h53, 8'h1A, 8'h02, 8'h01, 8'h00, 8'h00};
        clear_log();
        feed_q = '{32'h4E45531A, 32'h02010000};
        pulse_start(32'd8, s);
        wait_done(500, ok);
        n_cmp++; if (ok !== 1'b1) begin n_fail++; $display("FAIL eight_done_timeout: got %b want 1", ok); end
        n_cmp++; if (wr_dat.size() !== 8) begin n_fail++; $display("FAIL eight_count: got %0d want 8", wr_dat.size()); end
        if (wr_dat.size() == 8) begin
            for (int i = 0; i < 8; i++) begin
                n_cmp++; if (wr_dat[i] !== exp_b[i]) begin
                    n_fail++; $display("FAIL eight_dat[%0d]: got %h want %h", i, wr_dat[i], exp_b[i]); end
                n_cmp++; if (wr_addr[i] !== 25'(i)) begin
                    n_fail++; $display("FAIL eight_addr[%0d]: got %0d want %0d", i, wr_addr[i], i); end
            end
            for (int i = 1; i < 8; i++) begin
                n_cmp++; if (wr_cyc[i] - wr_cyc[i-1] !== ((i == 4) ? WG + 1 : WG)) begin
                    n_fail++; $display("FAIL eight_gap[%0d]: got %0d want %0d", i, wr_cyc[i] - wr_cyc[i-1], (i == 4) ? WG + 1 : WG); end
            end
            n_cmp++; if (wr_cyc[0] !== s + 2) begin
                n_fail++; $display("FAIL eight_first: got %0d want %0d", wr_cyc[0], s + 2); end
            n_cmp++; if (done_cyc - wr_cyc[7] !== WG + TC) begin
                n_fail++; $display("FAIL eight_tail: got %0d want %0d", done_cyc - wr_cyc[7], WG + TC); end
        end
        n_cmp++; if (dl_cnt !== done_cyc - s - 1) begin
            n_fail++; $display("FAIL eight_dl_len: got %0d want %0d", dl_cnt, done_cyc - s - 1); end
        n_cmp++; if (ioctl_download !== 1'b0 || busy !== 1'b0) begin
            n_fail++; $display("FAIL eight_idle: dl=%b busy=%b want 0 0", ioctl_download, busy); end
    endtask

    task automatic test_partial_word();
        logic [7:0] exp_b [6];
        int s;
        bit ok;
        exp_b = '{8'hAA, 8'hBB, 8'hCC, 8'hDD, 8'h11, 8'h22};
        clear_log();
        feed_q = '{32'hAABBCCDD, 32'h11223344, 32'hDEADBEEF};
        pulse_start(32'd6, s);
        wait_done(500, ok);
        n_cmp++; if (ok !== 1'b1) begin n_fail++; $display("FAIL partial_done_timeout: got %b want 1", ok); end
        n_cmp++; if (wr_dat.size() !== 6) begin n_fail++; $display("FAIL partial_count: got %0d want 6", wr_dat.size()); end
        if (wr_dat.size() == 6) begin
            for (int i = 0; i < 6; i++) begin
                n_cmp++; if (wr_dat[i] !== exp_b[i] || wr_addr[i] !== 25'(i)) begin
                    n_fail++; $display("FAIL partial_byte[%0d]: got %h@%0d want %h@%0d", i, wr_dat[i], wr_addr[i], exp_b[i], i); end
            end
        end
        n_cmp++; if (accepts !== 2) begin n_fail++; $display("FAIL partial_accepts: got %0d want 2", accepts); end
        n_cmp++; if (feed_q.size() !== 1) begin n_fail++; $display("FAIL partial_leftover: got %0d want 1", feed_q.size()); end
        feed_q.delete();
    endtask

    task automatic test_stalled_source();
        int s;
        bit ok;
        clear_log();
        stall  = 1'b1;
        feed_q = '{32'hCAFEF00D};
        pulse_start(32'd4, s);
        repeat (49) @(negedge clk);
        #1;
        n_cmp++; if (wr_dat.size() !== 0) begin n_fail++; $display("FAIL stall_no_wr: got %0d want 0", wr_dat.size()); end
        n_cmp++; if (dl_cnt !== 50) begin n_fail++; $display("FAIL stall_dl_cycles: got %0d want 50", dl_cnt); end
        n_cmp++; if (word_ready !== 1'b1 || ioctl_download !== 1'b1 || accepts !== 0) begin
            n_fail++; $display("FAIL stall_state: rdy=%b dl=%b acc=%0d want 1 1 0", word_ready, ioctl_download, accepts); end
        stall = 1'b0;
        wait_done(500, ok);
        n_cmp++; if (ok !== 1'b1) begin n_fail++; $display("FAIL stall_done_timeout: got %b want 1", ok); end
        n_cmp++; if (wr_dat.size() !== 4) begin n_fail++; $display("FAIL stall_count: got %0d want 4", wr_dat.size()); end
        if (wr_dat.size() == 4) begin
            n_cmp++; if (wr_cyc[0] !== accept_cyc + 1) begin
                n_fail++; $display("FAIL stall_latency: got %0d want %0d", wr_cyc[0], accept_cyc + 1); end
            n_cmp++; if ({wr_dat[0], wr_dat[1], wr_dat[2], wr_dat[3]} !== 32'hCAFEF00D) begin
                n_fail++; $display("FAIL stall_bytes: got %h%h%h%h want cafef00d", wr_dat[0], wr_dat[1], wr_dat[2], wr_dat[3]); end
        end
    endtask

    task automatic test_zero_and_ignored_start();
        int s;
        int s2;
        bit ok;
        clear_log();
        pulse_start(32'd0, s);
        repeat (3) @(negedge clk);
        pulse_start(32'd100, s2);
        wait_done(200, ok);
        n_cmp++; if (ok !== 1'b1) begin n_fail++; $display("FAIL zero_done_timeout: got %b want 1", ok); end
        n_cmp++; if (done_cyc - s !== TC + 1) begin n_fail++; $display("FAIL zero_done_cycle: got %0d want %0d", done_cyc - s, TC + 1); end
        n_cmp++; if (dl_cnt !== TC) begin n_fail++; $display("FAIL zero_dl_cycles: got %0d want %0d", dl_cnt, TC); end
        n_cmp++; if (wr_dat.size() !== 0) begin n_fail++; $display("FAIL zero_no_wr: got %0d want 0", wr_dat.size()); end

        clear_log();
        feed_q = '{32'h01020304};
        pulse_start(32'd4, s);
        for (int i = 0; i < 100 && wr_dat.size() == 0; i++) @(negedge clk);
        pulse_start(32'd100, s2);
        wait_done(500, ok);
        n_cmp++; if (ok !== 1'b1) begin n_fail++; $display("FAIL ign_done_timeout: got %b want 1", ok); end
        n_cmp++; if (wr_dat.size() !== 4 || accepts !== 1) begin
            n_fail++; $display("FAIL ign_count: got %0d bytes %0d words want 4 1", wr_dat.size(), accepts); end
        if (wr_dat.size() == 4) begin
            for (int i = 0; i < 4; i++) begin
                n_cmp++; if (wr_addr[i] !== 25'(i) || wr_dat[i] !== 8'(i + 1)) begin
                    n_fail++; $display("FAIL ign_byte[%0d]: got %h@%0d want %h@%0d", i, wr_dat[i], wr_addr[i], i + 1, i); end
            end
        end
        feed_q.delete();
    endtask

    task automatic test_reset_mid_transfer();
        int s;
        bit ok;
        clear_log();
        feed_q = '{32'h00010203, 32'h04050607, 32'h08090A0B, 32'h0C0D0E0F};
        pulse_start(32'd16, s);
        for (int i = 0; i < 200 && wr_dat.size() < 3; i++) @(negedge clk);
        repeat (2) @(negedge clk);
        #2;
        reset_n = 1'b0;
        #1;
        n_cmp++; if (ioctl_download !== 1'b0 || busy !== 1'b0 || word_ready !== 1'b0) begin
            n_fail++; $display("FAIL rst_ctrl: dl=%b busy=%b rdy=%b want 0 0 0", ioctl_download, busy, word_ready); end
        n_cmp++; if (ioctl_wr !== 1'b0 || done !== 1'b0 || ioctl_dout !== 8'h00 || ioctl_addr !== 25'd0) begin
            n_fail++; $display("FAIL rst_data: wr=%b done=%b dout=%h addr=%0d want 0 0 00 0", ioctl_wr, done, ioctl_dout, ioctl_addr); end
        @(negedge clk);
        reset_n = 1'b1;
        feed_q.delete();
        clear_log();
        feed_q = '{32'h00010203, 32'h04050607, 32'h08090A0B, 32'h0C0D0E0F};
        pulse_start(32'd16, s);
        wait_done(1000, ok);
        n_cmp++; if (ok !== 1'b1) begin n_fail++; $display("FAIL rst_done_timeout: got %b want 1", ok); end
        n_cmp++; if (wr_dat.size() !== 16) begin n_fail++; $display("FAIL rst_count: got %0d want 16", wr_dat.size()); end
        if (wr_dat.size() == 16) begin
            for (int i = 0; i < 16; i++) begin
                n_cmp++; if (wr_addr[i] !== 25'(i) || wr_dat[i] !== 8'(i)) begin
                    n_fail++; $display("FAIL rst_byte[%0d]: got %h@%0d want %h@%0d", i, wr_dat[i], wr_addr[i], i, i); end
            end
        end
    endtask

    initial begin
        test_reset();
        test_eight_byte();
        test_partial_word();
        test_stalled_source();
        test_zero_and_ignored_start();
        test_reset_mid_transfer();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/rom_byte_streamer.md
# rom_byte_streamer

Converts the 32-bit ROM file words delivered by the host data bridge into the byte-wide `ioctl_*` download stream consumed by the NES top level (`ioctl_download`, `ioctl_wr`, `ioctl_dout`). It sits directly upstream of the core wrapper and shares the PPU-domain clock with it. It paces byte writes so that GameLoader and the SDRAM channel 0 write path are never overrun. It holds `ioctl_download` across the whole file plus a tail, so the core's download reset and loader sequencing behave as for a byte-serial host.

## Interface
- `WRITE_GAP`, default 8: cycles from one `ioctl_wr` pulse to the next within a word; legal range ≥2.
- `TAIL_CYCLES`, default 16: cycles `ioctl_download` stays high after the last byte pulse; legal range ≥1.
- `clk` in 1: PPU-domain clock (21.47 MHz); all logic is on the rising edge.
- `reset_n` in 1: reset, asynchronous and active-low.
- `start` in 1: one-cycle pulse that begins a transfer; honoured only in IDLE.
- `file_size` in 32: file length in bytes, sampled on an accepted `start`.
- `word_valid` in 1: `word_data` is valid.
- `word_data` in 32: file word, big-endian (bits [31:24] are the first byte).
- `word_ready` out 1: the block accepts a word this cycle.
- `ioctl_download` out 1: a download is in progress.
- `ioctl_wr` out 1: one-cycle byte strobe.
- `ioctl_dout` out 8: byte data, valid while `ioctl_wr` is high.
- `ioctl_addr` out 25: byte offset of the current byte, starting at 0.
- `busy` out 1: the block is not in IDLE.
- `done` out 1: one-cycle pulse when the transfer finishes.

## Operation
- States are IDLE, FETCH, EMIT, GAP and TAIL.
- **IDLE:**
  - All outputs are low.
  - An accepted `start` latches `remaining = file_size` and clears the address and byte index.
  - On `start`, go to FETCH if `file_size != 0`, else go to TAIL.
- **FETCH:**
  - `word_ready = 1`.
  - On `word_valid`, latch `word_data`, set the byte index to 0 and go to EMIT.
- **EMIT (exactly one cycle):**
  - `ioctl_wr = 1`.
  - `ioctl_dout` = word byte[index], taken MSB-first.
  - `ioctl_addr` = current address.
  - On exit: increment the address, decrement `remaining`, increment the index, then go to GAP.
- **GAP (WRITE_GAP−1 cycles), on expiry:**
  - If `remaining == 0`, go to TAIL.
  - Else if index == 4, go to FETCH.
  - Else go to EMIT.
- **TAIL (TAIL_CYCLES cycles):** on expiry, pulse `done` and go to IDLE.
- A final partial word (`file_size` mod 4 ≠ 0) emits only the remaining bytes. Its unused low-order bytes are discarded.
- `ioctl_download` is high in every state except IDLE.
- `ioctl_addr` is 25 bits wide and wraps modulo 2^25. The top level never exceeds that; no error is flagged.
- `remaining` is a 32-bit down-counter and never underflows. The check is made before any further EMIT.
- `start` outside IDLE is ignored and has no effect on the transfer in progress.
- `word_valid` outside FETCH is ignored: no data is consumed and `word_ready` is 0.
- Asserting reset mid-transfer returns to IDLE immediately and drops `ioctl_download`. The partially loaded ROM is handled by the core's own download reset on the next transfer.

## Timing
- Reset values:
  - IDLE.
  - `word_ready`, `ioctl_download`, `ioctl_wr`, `busy` and `done` are 0.
  - `ioctl_dout = 8'h00`, `ioctl_addr = 0`.
- After the `start` cycle:
  - `ioctl_download` and `busy` go high on the next cycle.
  - `word_ready` goes high on that same cycle if `file_size != 0`.
- Word-accept latency: with a word accepted at cycle T (`word_valid && word_ready`), the first `ioctl_wr` is at T+1.
- Byte spacing: pulses within a word are exactly WRITE_GAP cycles apart. Across a word boundary the spacing is WRITE_GAP+1 plus any `word_valid` stall.
- `word_ready` is high only in FETCH, so at most one word is held at a time.
- End of transfer: with the last `ioctl_wr` at cycle L, TAIL is entered at L+WRITE_GAP. `ioctl_download` falls, and `done` pulses, at L+WRITE_GAP+TAIL_CYCLES.
- Zero-length file: `ioctl_download` is high for exactly TAIL_CYCLES cycles, then `done` pulses. No `ioctl_wr` occurs.

## Test plan
- **8-byte file:** `file_size=8`, words `0x4E45531A` then `0x02010000` presented with `word_valid` held high. Required: 8 `ioctl_wr` pulses with bytes `4E 45 53 1A 02 01 00 00` at addresses 0–7. In-word spacing is 8 cycles; the 3→4 boundary is 9. `done` pulses 8+16 cycles after the last pulse.
- **Partial final word:** `file_size=6`, words `0xAABBCCDD`, `0x11223344`. Required: bytes `AA BB CC DD 11 22` only. `word_ready` is never asserted a third time. `33`/`44` are never output.
- **Stalled source:** in a 4-byte file, `word_valid` is held low for 50 cycles in FETCH. Required: `ioctl_download` stays high, no `ioctl_wr` occurs, and the first pulse arrives 1 cycle after the accept.
- **Zero length and ignored start:** `file_size=0`. Required: `ioctl_download` high for 16 cycles, `done` on cycle 17, no `ioctl_wr`. Then a `start` pulsed mid-transfer with `file_size=100` must not alter the byte count or addresses of the running transfer.
- **Reset mid-operation:** assert `reset_n=0` after 3 bytes of a 16-byte file. Required: all outputs go to zero asynchronously. A subsequent `start` restarts from `ioctl_addr=0` with the full count.
